main_bus_ctrl: RTL and testbench



---
 rtl/main_bus_pkg.sv | 33 +++
 rtl/main_bus_ctrl_irq_prom.sv | 29 ++
 rtl/main_bus_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_main_bus_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_bus_pkg.sv
// Shared constants for the 1942 main-CPU bus glue: address regions, control
// register offsets, ROM banking base and the interrupt vector framing.
package main_bus_pkg;

  // Address-region prefixes, matched against the top bits of cpu_addr
  localparam logic [1:0] ROM_TOP_A15_14  = 2'b11;     // ROM is everything below C000
  localparam logic [4:0] IN_A15_11       = 5'b11000;  // C000-C7FF
  localparam logic [5:0] REG_A15_10      = 6'b110010; // C800-CBFF
  localparam logic [5:0] OBJ_A15_10      = 6'b110011; // CC00-CFFF
  localparam logic [4:0] CHAR_A15_11     = 5'b11010;  // D000-D7FF
  localparam logic [4:0] SCR_A15_11      = 5'b11011;  // D800-DFFF
  localparam logic [3:0] RAM_A15_12      = 4'hE;      // E000-EFFF

  typedef enum logic [2:0] {
    REG_SND0    = 3'd0,
    REG_SND1    = 3'd1,
    REG_SCRPOS0 = 3'd2,
    REG_SCRPOS1 = 3'd3,
    REG_FLIP    = 3'd4,
    REG_BRIGHT  = 3'd5,
    REG_BANK    = 3'd6,
    REG_NONE    = 3'd7
  } reg_off_e;

  localparam logic [2:0] ROM_BANK_BASE  = 3'd2;
  localparam logic [2:0] IRQ_VEC_PREFIX = 3'b110;
  localparam logic [2:0] IRQ_VEC_SUFFIX = 3'b111;

  function automatic logic [7:0] irq_vector(input logic [1:0] sel);
    return {IRQ_VEC_PREFIX, sel, IRQ_VEC_SUFFIX};
  endfunction

endpackage

// File: rtl/main_bus_ctrl_irq_prom.sv
// 256x4 line-timing PROM: downloadable write port, read at the current line
// registered on a clock enable.
module irq_prom_256x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen_i,
  input  logic [7:0] rd_addr_i,
  output logic [3:0] dout_o,
  input  logic [7:0] wr_addr_i,
  input  logic [3:0] din_i,
  input  logic       we_i
);

  logic [3:0] mem_q [0:255];
  logic [3:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= din_i;
  end

  // Only the output register is reset; the table itself is loaded by download
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout_q <= 4'h0;
    else if (cen_i)  dout_q <= mem_q[rd_addr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/main_bus_ctrl.sv
// Main Z80 bus glue for the 1942 core: decode, control registers, ROM banking,
// inputs, work RAM, read mux and line interrupts. Optional: CHEAT_INVINCIBLE_EN.
module main_bus_ctrl
  import main_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen3,
  input  logic        cen6,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_m1_n,
  output logic [7:0]  cpu_din,
  output logic        cpu_int_n,
  output logic        cpu_wait_n,
  output logic [12:0] cpu_ab,
  input  logic [7:0]  char_dout,
  input  logic [7:0]  scr_dout,
  input  logic        char_wait_n,
  input  logic        scr_wait_n,
  output logic        char_cs,
  output logic        scr_cs,
  output logic        obj_cs,
  output logic        snd_latch0_cs,
  output logic        snd_latch1_cs,
  output logic [1:0]  scrpos_cs,
  output logic [2:0]  scr_br,
  output logic        flip,
  output logic        sres_b,
  output logic        snd_int,
  output logic        coin_cnt,
  input  logic [7:0]  v,
  input  logic        lhbl,
  input  logic [5:0]  joystick1,
  input  logic [5:0]  joystick2,
  input  logic [1:0]  start_button,
  input  logic [1:0]  coin_input,
  input  logic [7:0]  dipsw_a,
  input  logic [7:0]  dipsw_b,
  input  logic        dip_flip,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  prog_addr,
  input  logic [3:0]  prog_din,
  input  logic        prom_we
`ifdef CHEAT_INVINCIBLE_EN
  ,
  input  logic        cheat_invincible
`endif
);

  logic       main_cs, in_cs, reg_cs, ram_cs, wr_sel, irq_ack;
  reg_off_e   reg_sel;
  logic [3:0] int_ctrl;
  logic [7:0] in_data, ram_data;

  assign main_cs = (cpu_addr[15:14] != ROM_TOP_A15_14);
  assign in_cs   = (cpu_addr[15:11] == IN_A15_11);
  assign reg_cs  = (cpu_addr[15:10] == REG_A15_10);
  assign obj_cs  = (cpu_addr[15:10] == OBJ_A15_10);
  assign char_cs = (cpu_addr[15:11] == CHAR_A15_11);
  assign scr_cs  = (cpu_addr[15:11] == SCR_A15_11);
  assign ram_cs  = (cpu_addr[15:12] == RAM_A15_12);
  assign cpu_ab  = cpu_addr[12:0];

  assign wr_sel  = reg_cs & ~cpu_wr_n;
  assign reg_sel = reg_off_e'(cpu_addr[2:0]);
  assign irq_ack = ~cpu_iorq_n & ~cpu_m1_n;

  assign snd_latch0_cs = wr_sel & (reg_sel == REG_SND0);
  assign snd_latch1_cs = wr_sel & (reg_sel == REG_SND1);
  assign scrpos_cs     = {wr_sel & (reg_sel == REG_SCRPOS1),
                          wr_sel & (reg_sel == REG_SCRPOS0)};
  assign cpu_wait_n    = char_wait_n & scr_wait_n;

  // Write-only control registers
  logic [1:0] bank_q, bank_d;
  logic [2:0] scr_br_q, scr_br_d;
  logic       flip_cpu_q, flip_cpu_d, sres_b_q, sres_b_d, coin_cnt_q, coin_cnt_d;
  logic       flip_q, flip_d;

  always_comb begin
    bank_d     = bank_q;
    scr_br_d   = scr_br_q;
    flip_cpu_d = flip_cpu_q;
    sres_b_d   = sres_b_q;
    coin_cnt_d = coin_cnt_q;
    flip_d     = flip_cpu_q ^ dip_flip;
    if (cen3 && wr_sel) begin
      case (reg_sel)
        REG_BANK:   bank_d   = cpu_dout[1:0];
        REG_BRIGHT: scr_br_d = cpu_dout[2:0];
        REG_FLIP: begin
          flip_cpu_d = cpu_dout[7];
          sres_b_d   = ~cpu_dout[4];
          coin_cnt_d = ~cpu_dout[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= 2'd0;
      scr_br_q   <= 3'd0;
      flip_cpu_q <= 1'b0;
      sres_b_q   <= 1'b1;
      coin_cnt_q <= 1'b0;
      flip_q     <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      scr_br_q   <= scr_br_d;
      flip_cpu_q <= flip_cpu_d;
      sres_b_q   <= sres_b_d;
      coin_cnt_q <= coin_cnt_d;
      flip_q     <= flip_d;
    end
  end

  assign scr_br   = scr_br_q;
  assign flip     = flip_q;
  assign sres_b   = sres_b_q;
  assign coin_cnt = coin_cnt_q;

  // Upper half of the CPU map is a 16 KB window onto banks 2..5
  assign rom_addr = {cpu_addr[15] ? (ROM_BANK_BASE + {1'b0, bank_q})
                                  : {2'b00, cpu_addr[14]},
                     cpu_addr[13:0]};

  always_comb begin
    case (cpu_addr[2:0])
      3'd0:    in_data = {coin_input, 4'hF, start_button};
      3'd1:    in_data = {2'b11, joystick1};
      3'd2:    in_data = {2'b11, joystick2};
      3'd3:    in_data = dipsw_a;
      3'd4:    in_data = dipsw_b;
      default: in_data = 8'hFF;
    endcase
  end

  logic [7:0] ram_mem [0:4095];
  logic [7:0] ram_dout_q;

  always_ff @(posedge clk) begin
    if (ram_cs && !cpu_wr_n && cen3) ram_mem[cpu_addr[11:0]] <= cpu_dout;
    if (cen3) ram_dout_q <= ram_mem[cpu_addr[11:0]];
  end

`ifdef CHEAT_INVINCIBLE_EN
  assign ram_data = (cheat_invincible && cpu_addr == 16'hE0A5) ? 8'h02 : ram_dout_q;
`else
  assign ram_data = ram_dout_q;
`endif

  always_comb begin
    cpu_din = rom_data;
    if (irq_ack)      cpu_din = irq_vector(int_ctrl[1:0]);
    else if (ram_cs)  cpu_din = ram_data;
    else if (char_cs) cpu_din = char_dout;
    else if (scr_cs)  cpu_din = scr_dout;
    else if (main_cs) cpu_din = rom_data;
    else if (in_cs)   cpu_din = in_data;
  end

  irq_prom_256x4 u_prom (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen_i     (cen6),
    .rd_addr_i (v),
    .dout_o    (int_ctrl),
    .wr_addr_i (prog_addr),
    .din_i     (prog_din),
    .we_i      (prom_we)
  );

  // Line interrupt: raised on the blanking edge, held until acknowledged
  logic lhbl_old_q, lhbl_old_d, snd_int_q, snd_int_d, int_n_q, int_n_d;

  always_comb begin
    lhbl_old_d = lhbl_old_q;
    snd_int_d  = snd_int_q;
    int_n_d    = int_n_q;
    if (cen3) begin
      lhbl_old_d = lhbl;
      snd_int_d  = int_ctrl[2];
      if (irq_ack)                               int_n_d = 1'b1;
      else if (lhbl && !lhbl_old_q && int_ctrl[3]) int_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_old_q <= 1'b0;
      snd_int_q  <= 1'b1;
      int_n_q    <= 1'b1;
    end else begin
      lhbl_old_q <= lhbl_old_d;
      snd_int_q  <= snd_int_d;
      int_n_q    <= int_n_d;
    end
  end

  assign snd_int   = snd_int_q;
  assign cpu_int_n = int_n_q;

endmodule

// File: tb/tb_main_bus_ctrl.sv
// Self-checking bench for main_bus_ctrl: directed steps plus randomized
// transactions against a behavioural model. Optional: CHEAT_INVINCIBLE_EN.
module tb_main_bus_ctrl;

  logic        clk = 0, rst_n = 0, cen3 = 0, cen6 = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0]  cpu_dout = 0;
  logic        cpu_wr_n = 1, cpu_iorq_n = 1, cpu_m1_n = 1;
  logic [7:0]  cpu_din;
  logic        cpu_int_n, cpu_wait_n;
  logic [12:0] cpu_ab;
  logic [7:0]  char_dout = 0, scr_dout = 0;
  logic        char_wait_n = 1, scr_wait_n = 1;
  logic        char_cs, scr_cs, obj_cs, snd_latch0_cs, snd_latch1_cs;
  logic [1:0]  scrpos_cs;
  logic [2:0]  scr_br;
  logic        flip, sres_b, snd_int, coin_cnt;
  logic [7:0]  v = 0;
  logic        lhbl = 0;
  logic [5:0]  joystick1 = 0, joystick2 = 0;
  logic [1:0]  start_button = 0, coin_input = 0;
  logic [7:0]  dipsw_a = 0, dipsw_b = 0;
  logic        dip_flip = 0;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data = 0;
  logic [7:0]  prog_addr = 0;
  logic [3:0]  prog_din = 0;
  logic        prom_we = 0;
  logic        cheat_invincible = 0;

  int checks = 0, errors = 0;
  logic [1:0] phase = 0;
  logic [3:0] prom_m [0:255];
  logic [7:0] ram_m [int];

  main_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cen3(cen3), .cen6(cen6),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr_n(cpu_wr_n),
    .cpu_iorq_n(cpu_iorq_n), .cpu_m1_n(cpu_m1_n), .cpu_din(cpu_din),
    .cpu_int_n(cpu_int_n), .cpu_wait_n(cpu_wait_n), .cpu_ab(cpu_ab),
    .char_dout(char_dout), .scr_dout(scr_dout), .char_wait_n(char_wait_n),
    .scr_wait_n(scr_wait_n), .char_cs(char_cs), .scr_cs(scr_cs), .obj_cs(obj_cs),
    .snd_latch0_cs(snd_latch0_cs), .snd_latch1_cs(snd_latch1_cs),
    .scrpos_cs(scrpos_cs), .scr_br(scr_br), .flip(flip), .sres_b(sres_b),
    .snd_int(snd_int), .coin_cnt(coin_cnt), .v(v), .lhbl(lhbl),
    .joystick1(joystick1), .joystick2(joystick2), .start_button(start_button),
    .coin_input(coin_input), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
    .dip_flip(dip_flip), .rom_addr(rom_addr), .rom_data(rom_data),
    .prog_addr(prog_addr), .prog_din(prog_din), .prom_we(prom_we)
`ifdef CHEAT_INVINCIBLE_EN
    , .cheat_invincible(cheat_invincible)
`endif
  );

  always #5 clk = ~clk;

  // cen6 on every other clock, cen3 on every fourth
  always @(negedge clk) begin
    phase = phase + 2'd1;
    cen6  = phase[0];
    cen3  = (phase == 2'd3);
  end

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cen3();
    do @(posedge clk); while (cen3 !== 1'b1);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_wr_n = 0;
    wait_cen3();
    cpu_wr_n = 1;
    $display("wr  %h <= %h", a, d);
  endtask

  function automatic logic [7:0] cab_model(input int off);
    case (off)
      0: return {coin_input, 4'hF, start_button};
      1: return {2'b11, joystick1};
      2: return {2'b11, joystick2};
      3: return dipsw_a;
      4: return dipsw_b;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected read data for any non-RAM address with no acknowledge in progress
  function automatic logic [7:0] din_model(input int a);
    if (a >= 'hD800 && a < 'hE000) return scr_dout;
    if (a >= 'hD000 && a < 'hD800) return char_dout;
    if (a < 'hC000)                return rom_data;
    if (a < 'hC800)                return cab_model(a % 8);
    return rom_data;
  endfunction

  function automatic logic [16:0] rom_model(input int a, input int b);
    if (a < 'h8000) return 17'(a);
    return 17'((2 + b) * 'h4000 + (a % 'h4000));
  endfunction

  function automatic logic [7:0] ram_model(input int a);
    if (cheat_invincible && a == 'hE0A5) return 8'h02;
    return ram_m[a];
  endfunction

  initial begin
    int a, d, b, off, r, guard;
    logic [7:0] vec;

    // PROM download while reset is held
    for (int i = 0; i < 256; i++) prom_m[i] = 4'($urandom);
    prom_m[10] = 4'hA;
    prom_m[20] = prom_m[20] & 4'h7;
    prom_we = 1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      prog_addr = 8'(i); prog_din = prom_m[i];
    end
    @(posedge clk); #1;
    prom_we = 0;
    check("rst_int_n", 17'(cpu_int_n), 17'd1);
    check("rst_snd_int", 17'(snd_int), 17'd1);
    check("rst_sres_b", 17'(sres_b), 17'd1);
    check("rst_coin", 17'(coin_cnt), 17'd0);
    check("rst_flip", 17'(flip), 17'd0);
    check("rst_br", 17'(scr_br), 17'd0);
    cpu_addr = 16'h8000; #1;
    check("rst_bank", rom_addr, 17'h08000);
    rst_n = 1;
    @(posedge clk); #1;

    // Cabinet inputs
    dipsw_a = 8'h5A; cpu_addr = 16'hC003; #1;
    check("cab_dipa", 17'(cpu_din), 17'h5A);
    joystick1 = 6'h3F; cpu_addr = 16'hC001; #1;
    check("cab_joy1", 17'(cpu_din), 17'hFF);
    cpu_addr = 16'hC007; #1;
    check("cab_c007", 17'(cpu_din), 17'hFF);
    for (int i = 0; i < 12; i++) begin
      joystick1 = 6'($urandom); joystick2 = 6'($urandom);
      start_button = 2'($urandom); coin_input = 2'($urandom);
      dipsw_a = 8'($urandom); dipsw_b = 8'($urandom);
      a = 'hC000 + int'($urandom_range(0, 'h7FF));
      cpu_addr = 16'(a); #1;
      $display("rd  %h cab", cpu_addr);
      check("cab_rand", 17'(cpu_din), 17'(din_model(a)));
    end

    // Address decode, selects and read mux over random non-RAM addresses
    for (int i = 0; i < 40; i++) begin
      do a = int'($urandom_range(0, 'hFFFF)); while (a >= 'hE000 && a < 'hF000);
      char_dout = 8'($urandom); scr_dout = 8'($urandom); rom_data = 8'($urandom);
      char_wait_n = 1'($urandom); scr_wait_n = 1'($urandom);
      cpu_addr = 16'(a); #1;
      $display("rd  %h decode", cpu_addr);
      check("dec_char", 17'(char_cs), 17'(a >= 'hD000 && a < 'hD800));
      check("dec_scr", 17'(scr_cs), 17'(a >= 'hD800 && a < 'hE000));
      check("dec_obj", 17'(obj_cs), 17'(a >= 'hCC00 && a < 'hD000));
      check("dec_latch", 17'({snd_latch0_cs, snd_latch1_cs, scrpos_cs}), 17'd0);
      check("dec_din", 17'(cpu_din), 17'(din_model(a)));
      check("dec_ab", 17'(cpu_ab), 17'(a % 'h2000));
      check("dec_wait", 17'(cpu_wait_n), 17'(char_wait_n && scr_wait_n));
    end
    cpu_addr = 16'hF000; rom_data = 8'h3C; #1;
    check("f000_sel", 17'({char_cs, scr_cs, obj_cs}), 17'd0);
    check("f000_din", 17'(cpu_din), 17'h3C);

    // Write-register selects
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cpu_addr = 16'('hC800 + 'h100 * (i % 4) + i); cpu_wr_n = 0; #1;
      $display("sel %h", cpu_addr);
      check("sel_snd0", 17'(snd_latch0_cs), 17'(i == 0));
      check("sel_snd1", 17'(snd_latch1_cs), 17'(i == 1));
      check("sel_scrpos", 17'(scrpos_cs), 17'(i == 2 ? 1 : (i == 3 ? 2 : 0)));
      cpu_wr_n = 1; #1;
      check("sel_rdonly", 17'({snd_latch0_cs, snd_latch1_cs, scrpos_cs}), 17'd0);
    end

    // ROM banking
    bus_write(16'hC806, 8'h03);
    cpu_addr = 16'h8000; #1;
    check("bank_8000", rom_addr, 17'h14000);
    cpu_addr = 16'h4000; #1;
    check("bank_4000", rom_addr, 17'h04000);
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 255)); b = d % 4;
      bus_write(16'hC806, 8'(d));
      for (int k = 0; k < 3; k++) begin
        a = int'($urandom_range(0, 'hBFFF));
        cpu_addr = 16'(a); #1;
        check("bank_rand", rom_addr, rom_model(a, b));
      end
    end

    // Flip / sound reset / coin counter
    dip_flip = 0;
    bus_write(16'hC804, 8'h91);
    check("flip_sres", 17'(sres_b), 17'd0);
    check("flip_coin", 17'(coin_cnt), 17'd0);
    @(posedge clk); #1;
    check("flip_on", 17'(flip), 17'd1);
    dip_flip = 1; #1;
    check("flip_hold", 17'(flip), 17'd1);
    @(posedge clk); #1;
    check("flip_dip", 17'(flip), 17'd0);
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(0, 255));
      dip_flip = 1'($urandom);
      bus_write(16'hC804, 8'(d));
      check("flip_sres_r", 17'(sres_b), 17'(((d >> 4) % 2) == 0));
      check("flip_coin_r", 17'(coin_cnt), 17'((d % 2) == 0));
      @(posedge clk); #1;
      check("flip_r", 17'(flip), 17'(((d >> 7) % 2) != int'(dip_flip)));
    end

    // Brightness
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 255));
      bus_write(16'hC805, 8'(d));
      check("bright", 17'(scr_br), 17'(d % 8));
    end

    // Work RAM
    bus_write(16'hE123, 8'h77); ram_m['hE123] = 8'h77;
    for (int i = 0; i < 12; i++) begin
      do a = 'hE000 + int'($urandom_range(0, 'hFFF)); while (a == 'hE123);
      d = int'($urandom_range(0, 255));
      bus_write(16'(a), 8'(d)); ram_m[a] = 8'(d);
    end
    cpu_addr = 16'hE123; wait_cen3();
    check("ram_e123", 17'(cpu_din), 17'h77);
    foreach (ram_m[k]) begin
      cpu_addr = 16'(k); wait_cen3();
      $display("rd  %h ram", cpu_addr);
      check("ram_rand", 17'(cpu_din), 17'(ram_model(k)));
    end

`ifdef CHEAT_INVINCIBLE_EN
    bus_write(16'hE0A5, 8'h00); ram_m['hE0A5] = 8'h00;
    cheat_invincible = 1; cpu_addr = 16'hE0A5; wait_cen3();
    check("cheat_on", 17'(cpu_din), 17'h02);
    cheat_invincible = 0; #1;
    check("cheat_off", 17'(cpu_din), 17'h00);
`endif

    // Line interrupt, directed on v=10
    cpu_addr = 16'h0000;
    v = 8'd10; lhbl = 0;
    repeat (2) wait_cen3();
    check("irq_snd_int", 17'(snd_int), 17'(prom_m[10][2]));
    check("irq_idle", 17'(cpu_int_n), 17'd1);
    lhbl = 1;
    guard = 0;
    while (cpu_int_n !== 1'b0 && guard < 16) begin @(posedge clk); #1; guard++; end
    check("irq_raise", 17'(cpu_int_n), 17'd0);
    cpu_iorq_n = 0; cpu_m1_n = 0; #1;
    check("irq_vector", 17'(cpu_din), 17'hD7);
    wait_cen3();
    check("irq_ack", 17'(cpu_int_n), 17'd1);
    cpu_iorq_n = 1; cpu_m1_n = 1;

    // No interrupt when the line's enable bit is clear
    v = 8'd20; lhbl = 0;
    repeat (2) wait_cen3();
    lhbl = 1;
    repeat (2) wait_cen3();
    check("irq_masked", 17'(cpu_int_n), 17'd1);
    check("irq_snd20", 17'(snd_int), 17'(prom_m[20][2]));

    // Acknowledge coinciding with the edge keeps the line high
    v = 8'd10; lhbl = 0;
    repeat (2) wait_cen3();
    cpu_iorq_n = 0; cpu_m1_n = 0; lhbl = 1;
    wait_cen3();
    cpu_iorq_n = 1; cpu_m1_n = 1;
    repeat (2) wait_cen3();
    check("irq_ack_wins", 17'(cpu_int_n), 17'd1);

    // Random lines
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 255));
      v = 8'(r); lhbl = 0;
      repeat (2) wait_cen3();
      check("irq_r_snd", 17'(snd_int), 17'(prom_m[r][2]));
      lhbl = 1;
      repeat (2) wait_cen3();
      $display("irq v=%0d ctrl=%h int_n=%b", r, prom_m[r], cpu_int_n);
      check("irq_r_int", 17'(cpu_int_n), 17'(prom_m[r][3] == 1'b0));
      cpu_iorq_n = 0; cpu_m1_n = 0; #1;
      vec = 8'hC7 + 8'(8 * (prom_m[r] % 4));
      check("irq_r_vec", 17'(cpu_din), 17'(vec));
      wait_cen3();
      cpu_iorq_n = 1; cpu_m1_n = 1;
      check("irq_r_ack", 17'(cpu_int_n), 17'd1);
    end

    // Asynchronous reset in the middle of activity
    bus_write(16'hC806, 8'h02);
    bus_write(16'hC805, 8'h07);
    bus_write(16'hC804, 8'h91);
    v = 8'd10; lhbl = 0;
    repeat (2) wait_cen3();
    lhbl = 1;
    repeat (2) wait_cen3();
    cpu_addr = 16'h8000;
    #2 rst_n = 0; #1;
    check("mid_rst_bank", rom_addr, 17'h08000);
    check("mid_rst_br", 17'(scr_br), 17'd0);
    check("mid_rst_sres", 17'(sres_b), 17'd1);
    check("mid_rst_coin", 17'(coin_cnt), 17'd0);
    check("mid_rst_flip", 17'(flip), 17'd0);
    check("mid_rst_int", 17'(cpu_int_n), 17'd1);
    check("mid_rst_snd", 17'(snd_int), 17'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
